// File: rtl/common.sv
// Shared RV32I decode types: opcodes, ALU operations, immediate formats, control bundle.
package common;

  localparam int unsigned REGISTER_FILE_SIZE = 32;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  // alt selects SUB/SRA; callers gate it so OP-IMM only honours it for shifts
  function automatic alu_op_t alu_of(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator; opcode bits are not needed, so only instr[31:7] enters.
module imm_gen
  import common::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with load-use hazard detection and ID/EX register.
// Optional stall counter port enabled by DECODE_STALL_COUNT_EN.
module decode_stage
  import common::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_ID_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_valid,
  input  logic [XLEN-1:0]     if_instr,
  input  logic [XLEN-1:0]     if_pc,
  output logic                id_ready,
  input  logic                flush,
  output logic [REG_ID_W-1:0] rf_read1_id,
  output logic [REG_ID_W-1:0] rf_read2_id,
  input  logic [XLEN-1:0]     rf_read1_data,
  input  logic [XLEN-1:0]     rf_read2_data,
  input  logic                ex_mem_read,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic                ex_ready,
  output logic                id_ex_valid,
  output logic [XLEN-1:0]     id_ex_pc,
  output logic [XLEN-1:0]     id_ex_rs1_data,
  output logic [XLEN-1:0]     id_ex_rs2_data,
  output logic [XLEN-1:0]     id_ex_imm,
  output logic [REG_ID_W-1:0] id_ex_rd,
  output ctrl_t               id_ex_ctrl
`ifdef DECODE_STALL_COUNT_EN
  ,
  output logic [31:0]         stall_count
`endif
);

  if (XLEN != 32 || (2 ** REG_ID_W) != REGISTER_FILE_SIZE) begin : g_param_check
    $error("decode_stage: only XLEN=32 with a matching REG_ID_W is supported");
  end

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  ctrl_t               ctrl;
  imm_fmt_t            fmt;
  logic                rs1_used;
  logic                rs2_used;
  logic [XLEN-1:0]     imm;
  logic [REG_ID_W-1:0] rd_eff;
  logic                hazard;
  logic                advance;

  assign opcode      = if_instr[6:0];
  assign funct3      = if_instr[14:12];
  assign rf_read1_id = if_instr[19:15];
  assign rf_read2_id = if_instr[24:20];

  imm_gen u_imm_gen (
    .instr (if_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  // Control decode; unknown opcodes flow downstream as illegal with no side effects
  always_comb begin
    ctrl     = '0;
    fmt      = IMM_NONE;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl.alu_op    = alu_of(funct3, if_instr[30]);
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alu_op    = alu_of(funct3, (funct3 == 3'b101) & if_instr[30]);
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        fmt            = IMM_I;
        rs1_used       = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        fmt            = IMM_I;
        rs1_used       = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        fmt            = IMM_S;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
        fmt         = IMM_B;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      OPC_LUI: begin
        ctrl.alu_op    = ALU_LUI;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        fmt            = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        fmt            = IMM_U;
      end
      OPC_JAL: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        fmt            = IMM_J;
      end
      OPC_JALR: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        fmt            = IMM_I;
        rs1_used       = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  assign rd_eff  = ctrl.reg_write ? if_instr[11:7] : '0;
  assign hazard  = if_valid & ex_mem_read & (ex_rd != '0) &
                   ((rs1_used & (ex_rd == rf_read1_id)) | (rs2_used & (ex_rd == rf_read2_id)));
  assign advance = ~id_ex_valid | ex_ready;
  assign id_ready = flush | (advance & ~hazard);

  // ID/EX register: reset > flush > hold > bubble > load
  always_ff @(posedge clk) begin
    if (reset || flush || (advance && hazard)) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rd       <= '0;
      id_ex_ctrl     <= '0;
    end else if (advance) begin
      id_ex_valid    <= if_valid;
      id_ex_pc       <= if_pc;
      id_ex_rs1_data <= rf_read1_data;
      id_ex_rs2_data <= rf_read2_data;
      id_ex_imm      <= imm;
      id_ex_rd       <= rd_eff;
      id_ex_ctrl     <= ctrl;
    end
  end

`ifdef DECODE_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (hazard && advance && !flush) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage; expected ID/EX contents are queued as each word is driven.
module tb_decode_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        reset, if_valid, id_ready, flush, ex_mem_read, ex_ready, id_ex_valid;
  logic [31:0] if_instr, if_pc, rf_read1_data, rf_read2_data;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  rf_read1_id, rf_read2_id, ex_rd, id_ex_rd;
  ctrl_t       id_ex_ctrl;
`ifdef DECODE_STALL_COUNT_EN
  logic [31:0] stall_count;
  logic [31:0] cnt_before;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } idex_t;

  idex_t exp_q[$];
  idex_t obs, exp_e;
  int    n_cmp = 0;
  int    n_bad = 0;

  localparam logic [31:0] I_ADDI = 32'hFFB00093;
  localparam logic [31:0] I_ADD5 = 32'h00728333;  // add x6,x5,x7
  localparam logic [31:0] I_ADD8 = 32'h00740333;  // add x6,x8,x7
  localparam logic [31:0] I_LW   = 32'h00812283;
  localparam logic [31:0] I_SW   = 32'hFE712E23;
  localparam logic [31:0] I_LUI  = 32'h123451B7;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk            (clk),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .flush          (flush),
    .rf_read1_id    (rf_read1_id),
    .rf_read2_id    (rf_read2_id),
    .rf_read1_data  (rf_read1_data),
    .rf_read2_data  (rf_read2_data),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_ready       (ex_ready),
    .id_ex_valid    (id_ex_valid),
    .id_ex_pc       (id_ex_pc),
    .id_ex_rs1_data (id_ex_rs1_data),
    .id_ex_rs2_data (id_ex_rs2_data),
    .id_ex_imm      (id_ex_imm),
    .id_ex_rd       (id_ex_rd),
`ifdef DECODE_STALL_COUNT_EN
    .stall_count    (stall_count),
`endif
    .id_ex_ctrl     (id_ex_ctrl)
  );

  assign obs = {id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_rd, id_ex_ctrl};

  function automatic ctrl_t mk(input alu_op_t a, input logic s, input logic mr, input logic mw,
                               input logic rw, input logic br, input logic j, input logic il);
    mk = {a, s, mr, mw, rw, br, j, il};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    if_valid      = 1'b1;
    if_instr      = ins;
    if_pc         = pc;
    rf_read1_data = $urandom;
    rf_read2_data = $urandom;
  endtask

  task automatic push(input logic [31:0] imm, input logic [4:0] rd, input ctrl_t c);
    exp_q.push_back({if_pc, rf_read1_data, rf_read2_data, imm, rd, c});
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rf_read1_data = '0; rf_read2_data = '0; ex_mem_read = 1'b0; ex_rd = '0; ex_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (id_ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", id_ex_valid); end
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_fields got=%h want=0", obs); end
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", id_ready); end
`ifdef DECODE_STALL_COUNT_EN
    n_cmp++; if (stall_count !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", stall_count); end
`endif
  endtask

  task automatic test_decode;
    logic [31:0] ins, imm;
    logic [4:0]  rd;
    ctrl_t       c;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:  begin ins = I_ADDI;       imm = 32'hFFFFFFFB; rd = 5'd1; c = mk(ALU_ADD, 1, 0, 0, 1, 0, 0, 0); end
        1:  begin ins = 32'hFE208CE3; imm = 32'hFFFFFFF8; rd = 5'd0; c = mk(ALU_SUB, 0, 0, 0, 0, 1, 0, 0); end
        2:  begin ins = 32'h000000FF; imm = 32'h0;        rd = 5'd0; c = mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 1); end
        3:  begin ins = I_LW;         imm = 32'h8;        rd = 5'd5; c = mk(ALU_ADD, 1, 1, 0, 1, 0, 0, 0); end
        4:  begin ins = I_SW;         imm = 32'hFFFFFFFC; rd = 5'd0; c = mk(ALU_ADD, 1, 0, 1, 0, 0, 0, 0); end
        5:  begin ins = I_LUI;        imm = 32'h12345000; rd = 5'd3; c = mk(ALU_LUI, 1, 0, 0, 1, 0, 0, 0); end
        6:  begin ins = 32'hFFDFF0EF; imm = 32'hFFFFFFFC; rd = 5'd1; c = mk(ALU_ADD, 1, 0, 0, 1, 0, 1, 0); end
        7:  begin ins = 32'h40728333; imm = 32'h0;        rd = 5'd6; c = mk(ALU_SUB, 0, 0, 0, 1, 0, 0, 0); end
        8:  begin ins = 32'h40315093; imm = 32'h403;      rd = 5'd1; c = mk(ALU_SRA, 1, 0, 0, 1, 0, 0, 0); end
        9:  begin ins = 32'hFFFFF117; imm = 32'hFFFFF000; rd = 5'd2; c = mk(ALU_ADD, 1, 0, 0, 1, 0, 0, 0); end
        10: begin ins = 32'h00008067; imm = 32'h0;        rd = 5'd0; c = mk(ALU_ADD, 1, 0, 0, 1, 0, 1, 0); end
        default: begin ins = 32'h003140B3; imm = 32'h0;   rd = 5'd1; c = mk(ALU_XOR, 0, 0, 0, 1, 0, 0, 0); end
      endcase
      drive(ins, 32'h1000 + 32'(4 * i));
      #1;
      n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL dec_ready[%0d] got=%b want=1", i, id_ready); end
      n_cmp++;
      if ({rf_read1_id, rf_read2_id} !== {ins[19:15], ins[24:20]}) begin
        n_bad++; $display("FAIL dec_rf_ids[%0d] got=%0d,%0d want=%0d,%0d", i, rf_read1_id, rf_read2_id, ins[19:15], ins[24:20]);
      end
      push(imm, rd, c);
      tick();
      exp_e = exp_q.pop_front();
      n_cmp++;
      if (id_ex_valid !== 1'b1 || obs !== exp_e) begin
        n_bad++; $display("FAIL dec_idex[%0d] got v=%b %h want v=1 %h", i, id_ex_valid, obs, exp_e);
      end
    end
    if_valid = 1'b0;
    tick();
    n_cmp++; if (id_ex_valid !== 1'b0) begin n_bad++; $display("FAIL dec_idle got=%b want=0", id_ex_valid); end
  endtask

  task automatic test_load_use;
    logic [31:0] ins, imm;
    logic [4:0]  rd, erd;
    logic        mr, stall;
    ctrl_t       c;
    ex_ready = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    drive(I_ADD5, 32'h2000);
    #1;
    n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL lu_ready got=%b want=0", id_ready); end
    tick();
    n_cmp++;
    if (id_ex_valid !== 1'b0 || obs !== '0) begin
      n_bad++; $display("FAIL lu_bubble got v=%b %h want v=0 0", id_ex_valid, obs);
    end
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL lu_release got=%b want=1", id_ready); end
    push(32'h0, 5'd6, mk(ALU_ADD, 0, 0, 0, 1, 0, 0, 0));
    tick();
    exp_e = exp_q.pop_front();
    n_cmp++;
    if (id_ex_valid !== 1'b1 || obs !== exp_e) begin
      n_bad++; $display("FAIL lu_issue got v=%b %h want v=1 %h", id_ex_valid, obs, exp_e);
    end
    for (int j = 0; j < 7; j++) begin
      case (j)
        0: begin mr = 1; erd = 5'd0; ins = I_ADD5; stall = 0; end
        1: begin mr = 1; erd = 5'd5; ins = I_ADD8; stall = 0; end
        2: begin mr = 1; erd = 5'd7; ins = I_ADD8; stall = 1; end
        3: begin mr = 1; erd = 5'd8; ins = I_LUI;  stall = 0; end
        4: begin mr = 1; erd = 5'd2; ins = I_SW;   stall = 1; end
        5: begin mr = 1; erd = 5'd7; ins = I_SW;   stall = 1; end
        default: begin mr = 0; erd = 5'd5; ins = I_ADD5; stall = 0; end
      endcase
      if (ins == I_LUI) begin imm = 32'h12345000; rd = 5'd3; c = mk(ALU_LUI, 1, 0, 0, 1, 0, 0, 0); end
      else if (ins == I_SW) begin imm = 32'hFFFFFFFC; rd = 5'd0; c = mk(ALU_ADD, 1, 0, 1, 0, 0, 0, 0); end
      else begin imm = 32'h0; rd = 5'd6; c = mk(ALU_ADD, 0, 0, 0, 1, 0, 0, 0); end
      ex_mem_read = mr; ex_rd = erd;
      drive(ins, 32'h2100 + 32'(4 * j));
      #1;
      n_cmp++; if (id_ready !== !stall) begin n_bad++; $display("FAIL lu_case_ready[%0d] got=%b want=%b", j, id_ready, !stall); end
      if (!stall) push(imm, rd, c);
      tick();
      n_cmp++; if (id_ex_valid !== !stall) begin n_bad++; $display("FAIL lu_case_valid[%0d] got=%b want=%b", j, id_ex_valid, !stall); end
      if (!stall) begin
        exp_e = exp_q.pop_front();
        n_cmp++; if (obs !== exp_e) begin n_bad++; $display("FAIL lu_case_idex[%0d] got=%h want=%h", j, obs, exp_e); end
      end
    end
    ex_mem_read = 1'b0; ex_rd = 5'd0;
  endtask

  task automatic test_backpressure;
    ex_ready = 1'b1;
    drive(I_ADDI, 32'h3000);
    push(32'hFFFFFFFB, 5'd1, mk(ALU_ADD, 1, 0, 0, 1, 0, 0, 0));
    tick();
    n_cmp++;
    if (id_ex_valid !== 1'b1 || obs !== exp_q[0]) begin
      n_bad++; $display("FAIL bp_load got v=%b %h want v=1 %h", id_ex_valid, obs, exp_q[0]);
    end
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(I_LW, 32'h3004);
      #1;
      n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got=%b want=0", k, id_ready); end
      tick();
      n_cmp++;
      if (id_ex_valid !== 1'b1 || obs !== exp_q[0]) begin
        n_bad++; $display("FAIL bp_hold[%0d] got v=%b %h want v=1 %h", k, id_ex_valid, obs, exp_q[0]);
      end
    end
    ex_ready = 1'b1;
    #1;
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL bp_resume_ready got=%b want=1", id_ready); end
    void'(exp_q.pop_front());
    push(32'h8, 5'd5, mk(ALU_ADD, 1, 1, 0, 1, 0, 0, 0));
    tick();
    exp_e = exp_q.pop_front();
    n_cmp++;
    if (id_ex_valid !== 1'b1 || obs !== exp_e) begin
      n_bad++; $display("FAIL bp_resume got v=%b %h want v=1 %h", id_ex_valid, obs, exp_e);
    end
  endtask

  task automatic test_flush;
    for (int f = 0; f < 2; f++) begin
      ex_ready = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd5; flush = 1'b1;
      drive(I_ADD5, 32'h4000);
`ifdef DECODE_STALL_COUNT_EN
      cnt_before = stall_count;
`endif
      #1;
      n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL fl_ready[%0d] got=%b want=1", f, id_ready); end
      tick();
      n_cmp++; if (id_ex_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid[%0d] got=%b want=0", f, id_ex_valid); end
`ifdef DECODE_STALL_COUNT_EN
      n_cmp++;
      if (stall_count !== cnt_before) begin
        n_bad++; $display("FAIL fl_cnt[%0d] got=%0d want=%0d", f, stall_count, cnt_before);
      end
`endif
    end
    flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; ex_ready = 1'b1; if_valid = 1'b0;
    tick();
  endtask

`ifdef DECODE_STALL_COUNT_EN
  task automatic test_stall_count;
    reset = 1'b1; tick(); reset = 1'b0;
    ex_ready = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    drive(I_ADD5, 32'h5000);
    for (int s = 0; s < 4; s++) tick();
    n_cmp++; if (stall_count !== 32'd4) begin n_bad++; $display("FAIL sc_four got=%0d want=4", stall_count); end
    ex_mem_read = 1'b0;
    drive(I_ADDI, 32'h5004);
    tick();
    ex_ready = 1'b0; ex_mem_read = 1'b1;
    drive(I_ADD5, 32'h5008);
    tick(); tick();
    n_cmp++; if (stall_count !== 32'd4) begin n_bad++; $display("FAIL sc_no_adv got=%0d want=4", stall_count); end
    ex_ready = 1'b1; ex_mem_read = 1'b0; if_valid = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_stall;
    ex_ready = 1'b1; ex_mem_read = 1'b0;
    drive(I_ADDI, 32'h6000);
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    drive(I_ADD5, 32'h6004);
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (id_ex_valid !== 1'b0 || obs !== '0) begin
      n_bad++; $display("FAIL rms_state got v=%b %h want v=0 0", id_ex_valid, obs);
    end
`ifdef DECODE_STALL_COUNT_EN
    n_cmp++; if (stall_count !== 32'd0) begin n_bad++; $display("FAIL rms_cnt got=%0d want=0", stall_count); end
`endif
    reset = 1'b0; ex_mem_read = 1'b0; if_valid = 1'b0;
    #1;
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL rms_ready got=%b want=1", id_ready); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_backpressure();
    test_flush();
`ifdef DECODE_STALL_COUNT_EN
    test_stall_count();
`endif
    test_reset_mid_stall();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
